redmule_z_drain: RTL and testbench

REDMULE_Z_DRAIN -- requirements
Module: redmule_z_drain

---
 rtl/fpnew_pkg.sv | 24 ++
 rtl/redmule_pkg.sv | 13 +
 rtl/redmule_z_drain_if.sv | 24 ++
 rtl/redmule_z_drain.sv | 185 ++++++++++++++++++
 tb/tb_redmule_z_drain.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpnew_pkg.sv
// Floating-point format enumeration and width lookup used to size Z-row
// elements. This is a minimal subset of the FPnew package.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32,
        FP64,
        FP16,
        FP8,
        FP16ALT
    } fp_format_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 16;
        endcase
    endfunction

endpackage

// File: rtl/redmule_pkg.sv
// Shared RedMulE constants and the Z-drain state encoding.
package redmule_pkg;

    localparam int unsigned ARRAY_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        DONE
    } z_drain_state_e;

endpackage

// File: rtl/redmule_z_drain_if.sv
// Row-write channel from the Z drain to the memory side, with a valid/ready
// handshake.
interface redmule_z_drain_if #(
    parameter int unsigned DW = 288
) ();
    localparam int unsigned STRBW = DW / 8;

    logic             wr_valid;
    logic             wr_ready;
    logic [DW-1:0]    wr_data;
    logic [STRBW-1:0] wr_strb;
    logic [31:0]      wr_addr;
    logic             wr_last;

    modport master (
        output wr_valid, wr_data, wr_strb, wr_addr, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_data, wr_strb, wr_addr, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/redmule_z_drain.sv
// Drains one tile of Z rows from the Z buffer onto the row-write channel,
// then discards the unused rows so the buffer always shifts W times per tile.
module redmule_z_drain
    import redmule_pkg::*;
#(
    parameter int unsigned          DW       = 288,
    parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::FP16,
    parameter int unsigned          Width    = ARRAY_WIDTH,
    localparam int unsigned         BITW     = fpnew_pkg::fp_width(FpFormat),
    localparam int unsigned         W        = Width,
    localparam int unsigned         D        = DW / BITW,
    localparam int unsigned         STRBW    = DW / 8,
    localparam int unsigned         RW       = $clog2(W) + 1,
    localparam int unsigned         CW       = $clog2(D) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [RW-1:0]    rows_lftovr_i,
    input  logic [CW-1:0]    cols_lftovr_i,
    input  logic [31:0]      base_addr_i,
    input  logic [31:0]      stride_i,
    input  logic [DW-1:0]    z_data_i,
    output logic             z_store_o,
    output logic             wr_valid_o,
    input  logic             wr_ready_i,
    output logic [DW-1:0]    wr_data_o,
    output logic [STRBW-1:0] wr_strb_o,
    output logic [31:0]      wr_addr_o,
    output logic             wr_last_o,
    output logic             busy_o,
    output logic             done_o
);

    z_drain_state_e   state_q, state_d;
    logic [RW-1:0]    sent_q, sent_d;
    logic [RW-1:0]    popped_q, popped_d;
    logic [RW-1:0]    y_width_q, y_width_d;
    logic [31:0]      next_addr_q, next_addr_d;
    logic [31:0]      stride_q, stride_d;
    logic             wr_valid_q, wr_valid_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic [STRBW-1:0] wr_strb_q, wr_strb_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic             wr_last_q, wr_last_d;
    logic             done_q, done_d;

    logic             out_free;
    logic [RW-1:0]    rows_eff;
    int unsigned      depth;
    int unsigned      n_bytes;

    assign out_free = !wr_valid_q || wr_ready_i;

    always_comb begin
        state_d     = state_q;
        sent_d      = sent_q;
        popped_d    = popped_q;
        y_width_d   = y_width_q;
        next_addr_d = next_addr_q;
        stride_d    = stride_q;
        wr_valid_d  = wr_valid_q;
        wr_data_d   = wr_data_q;
        wr_strb_d   = wr_strb_q;
        wr_addr_d   = wr_addr_q;
        wr_last_d   = wr_last_q;
        done_d      = done_q;
        z_store_o   = 1'b0;
        rows_eff    = (rows_lftovr_i == '0) ? RW'(W) : rows_lftovr_i;
        depth       = (cols_lftovr_i == '0) ? D : 32'(cols_lftovr_i);
        n_bytes     = depth * BITW / 8;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    y_width_d   = rows_eff;
                    next_addr_d = base_addr_i;
                    stride_d    = stride_i;
                    sent_d      = '0;
                    popped_d    = '0;
                    wr_last_d   = 1'b0;
                    for (int unsigned b = 0; b < STRBW; b++) begin
                        wr_strb_d[b] = (b < n_bytes);
                    end
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (out_free) begin
                    if (sent_q < y_width_q) begin
                        wr_data_d   = z_data_i;
                        wr_valid_d  = 1'b1;
                        wr_addr_d   = next_addr_q;
                        next_addr_d = next_addr_q + stride_q;
                        wr_last_d   = (sent_q == y_width_q - RW'(1));
                        z_store_o   = 1'b1;
                        sent_d      = sent_q + RW'(1);
                        popped_d    = popped_q + RW'(1);
                    end else begin
                        wr_valid_d  = 1'b0;
                        wr_last_d   = 1'b0;
                    end
                end
                // A full-height tile has nothing to flush and goes straight to DONE.
                if (sent_d == y_width_q) begin
                    if (popped_d != RW'(W)) begin
                        state_d = FLUSH;
                    end else if (!wr_valid_d) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    wr_valid_d = 1'b0;
                    wr_last_d  = 1'b0;
                end
                if (popped_q != RW'(W)) begin
                    z_store_o = 1'b1;
                    popped_d  = popped_q + RW'(1);
                end
                if (popped_d == RW'(W) && !wr_valid_d) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d    = IDLE;
            sent_d     = '0;
            popped_d   = '0;
            wr_valid_d = 1'b0;
            wr_last_d  = 1'b0;
            done_d     = 1'b0;
            z_store_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sent_q      <= '0;
            popped_q    <= '0;
            y_width_q   <= '0;
            next_addr_q <= '0;
            stride_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            wr_addr_q   <= '0;
            wr_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sent_q      <= sent_d;
            popped_q    <= popped_d;
            y_width_q   <= y_width_d;
            next_addr_q <= next_addr_d;
            stride_q    <= stride_d;
            wr_valid_q  <= wr_valid_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
            wr_addr_q   <= wr_addr_d;
            wr_last_q   <= wr_last_d;
            done_q      <= done_d;
        end
    end

    assign wr_valid_o = wr_valid_q;
    assign wr_data_o  = wr_data_q;
    assign wr_strb_o  = wr_strb_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_last_o  = wr_last_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_redmule_z_drain.sv
// Scoreboard bench for redmule_z_drain: a Z-buffer model feeds rows, tiles are
// predicted from address/strobe arithmetic, and a monitor checks every write.
module tb_redmule_z_drain;

    localparam int W     = 12;
    localparam int D     = 18;
    localparam int DW    = 288;
    localparam int STRBW = DW / 8;
    localparam int RW    = $clog2(W) + 1;
    localparam int CW    = $clog2(D) + 1;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [31:0]      addr;
        logic [STRBW-1:0] strb;
        logic             last;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          start;
    logic [RW-1:0] rows_lftovr;
    logic [CW-1:0] cols_lftovr;
    logic [31:0]   base_addr;
    logic [31:0]   stride;
    logic [DW-1:0] z_data;
    logic          z_store;
    logic          busy;
    logic          done;

    redmule_z_drain_if #(.DW(DW)) bus ();

    redmule_z_drain #(.DW(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .start_i       (start),
        .rows_lftovr_i (rows_lftovr),
        .cols_lftovr_i (cols_lftovr),
        .base_addr_i   (base_addr),
        .stride_i      (stride),
        .z_data_i      (z_data),
        .z_store_o     (z_store),
        .wr_valid_o    (bus.wr_valid),
        .wr_ready_i    (bus.wr_ready),
        .wr_data_o     (bus.wr_data),
        .wr_strb_o     (bus.wr_strb),
        .wr_addr_o     (bus.wr_addr),
        .wr_last_o     (bus.wr_last),
        .busy_o        (busy),
        .done_o        (done)
    );

    wr_t           exp_q[$];
    logic [DW-1:0] zq[$];
    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    int            acc_cnt = 0;
    int            tile_pops = 0;
    int            cyc = 0;
    int            first_acc = -1;
    int            last_acc = -1;
    int            ready_mode = 0;
    bit            pop_pending = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Z-buffer model and write-side ready generator, both updated just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (pop_pending && zq.size() > 0) void'(zq.pop_front());
        pop_pending = 1'b0;
        z_data = (zq.size() > 0) ? zq[0] : '0;
        case (ready_mode)
            0:       bus.wr_ready = 1'b1;
            1:       bus.wr_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: bus.wr_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: compares every presented row against the head of the expected queue.
    always @(negedge clk) begin
        wr_t got;
        if (!rst && !clear) begin
            if (done) done_cnt++;
            if (z_store) tile_pops++;
            if (bus.wr_valid) begin
                total++;
                got = {bus.wr_data, bus.wr_addr, bus.wr_strb, bus.wr_last};
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_write: addr act=%h req=none", bus.wr_addr);
                end else begin
                    if (got !== exp_q[0]) begin
                        bad++;
                        $display("[TB] FAIL row: addr act=%h req=%h last act=%b req=%b strb act=%h req=%h data act=%h req=%h",
                                 got.addr, exp_q[0].addr, got.last, exp_q[0].last,
                                 got.strb, exp_q[0].strb, got.data, exp_q[0].data);
                    end
                    if (bus.wr_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                        if (first_acc < 0) first_acc = cyc;
                        last_acc = cyc;
                    end
                end
            end
        end
        if (clear) begin
            total++;
            if (z_store !== 1'b0) begin
                bad++;
                $display("[TB] FAIL store_during_clear: act=%b req=0", z_store);
            end
        end
        pop_pending = z_store && !rst && !clear;
    end

    task automatic checkVal(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: act=%0d req=%0d", name, act, req);
        end
    endtask

    task automatic checkZero(input string name);
        checkVal({name, "_valid"}, int'(bus.wr_valid), 0);
        checkVal({name, "_data_nz"}, int'(|bus.wr_data), 0);
        checkVal({name, "_addr_nz"}, int'(|bus.wr_addr), 0);
        checkVal({name, "_strb_nz"}, int'(|bus.wr_strb), 0);
        checkVal({name, "_last"}, int'(bus.wr_last), 0);
        checkVal({name, "_busy"}, int'(busy), 0);
        checkVal({name, "_done"}, int'(done), 0);
        checkVal({name, "_zstore"}, int'(z_store), 0);
    endtask

    task automatic applyStimulus(input int rows, input int cols, input logic [31:0] base,
                                 input logic [31:0] strd, input bit release_rst);
        logic [DW-1:0]    row [W];
        logic [STRBW-1:0] mask;
        int               y;
        int               dep;
        @(posedge clk);
        #1;
        y   = (rows == 0) ? W : rows;
        dep = (cols == 0) ? D : cols;
        for (int b = 0; b < STRBW; b++) mask[b] = (b < dep * 2);
        zq.delete();
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < DW / 32; j++) row[i][j*32 +: 32] = $urandom();
            zq.push_back(row[i]);
        end
        for (int k = 0; k < y; k++) begin
            exp_q.push_back({row[k], base + 32'(k) * strd, mask, k == y - 1});
        end
        tile_pops   = 0;
        done_cnt    = 0;
        acc_cnt     = 0;
        first_acc   = -1;
        last_acc    = -1;
        if (release_rst) rst = 1'b0;
        rows_lftovr = RW'(rows);
        cols_lftovr = CW'(cols);
        base_addr   = base;
        stride      = strd;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
    endtask

    task automatic checkOutput(input string name, input bit consec, input int y);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) $display("[TB] FAIL %s_timeout: act=no_done req=done", name);
        repeat (2) @(negedge clk);
        checkVal({name, "_done_pulses"}, done_cnt, 1);
        checkVal({name, "_zstore_count"}, tile_pops, W);
        checkVal({name, "_rows_left"}, exp_q.size(), 0);
        checkVal({name, "_rows_accepted"}, acc_cnt, y);
        checkVal({name, "_busy_after"}, int'(busy), 0);
        if (consec) checkVal({name, "_consecutive"}, last_acc - first_acc, y - 1);
    endtask

    task automatic waitAccepted(input int n_rows);
        int n = 0;
        while (acc_cnt < n_rows && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkVal("wait_accepted", (acc_cnt >= n_rows) ? 1 : 0, 1);
    endtask

    initial begin
        rst          = 1'b1;
        clear        = 1'b0;
        start        = 1'b0;
        rows_lftovr  = '0;
        cols_lftovr  = '0;
        base_addr    = '0;
        stride       = '0;
        z_data       = '0;
        bus.wr_ready = 1'b1;
        #3;
        checkZero("reset");
        repeat (2) @(posedge clk);

        $display("[TB] full tile");
        applyStimulus(0, 0, 32'h1000, 32'h40, 1'b1);
        checkOutput("full", 1'b1, W);

        $display("[TB] partial tile");
        applyStimulus(5, 7, 32'h2000, 32'h20, 1'b0);
        checkOutput("partial", 1'b1, 5);

        $display("[TB] backpressure with ignored start");
        ready_mode = 1;
        applyStimulus(0, 0, 32'h3000, 32'h44, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rows_lftovr = RW'(2);
        cols_lftovr = CW'(3);
        base_addr   = 32'h0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        checkOutput("bp_full", 1'b0, W);
        applyStimulus(7, 1, 32'h3800, 32'h8, 1'b0);
        checkOutput("bp_partial", 1'b0, 7);
        ready_mode = 0;

        $display("[TB] clear mid-tile");
        applyStimulus(0, 0, 32'h4000, 32'h40, 1'b0);
        waitAccepted(6);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        checkVal("clear_valid", int'(bus.wr_valid), 0);
        checkVal("clear_busy", int'(busy), 0);
        exp_q.delete();
        zq.delete();
        repeat (5) @(negedge clk);
        checkVal("clear_no_done", done_cnt, 0);
        applyStimulus(0, 0, 32'h5000, 32'h40, 1'b0);
        checkOutput("after_clear", 1'b1, W);

        $display("[TB] async reset mid-tile");
        applyStimulus(0, 0, 32'h6000, 32'h80, 1'b0);
        waitAccepted(3);
        #2;
        rst = 1'b1;
        #1;
        checkZero("async_rst");
        @(negedge clk);
        exp_q.delete();
        zq.delete();
        repeat (2) @(posedge clk);
        applyStimulus(4, 18, 32'h7000, 32'h10, 1'b1);
        checkOutput("after_rst", 1'b1, 4);

        $display("[TB] address wrap");
        applyStimulus(3, 0, 32'hFFFF_FFC0, 32'h40, 1'b0);
        checkOutput("wrap", 1'b1, 3);

        $display("[TB] random tiles");
        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            int r;
            r = $urandom_range(0, W);
            applyStimulus(r, $urandom_range(0, D), $urandom(), $urandom(), 1'b0);
            checkOutput("random", 1'b0, (r == 0) ? W : r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
